muldiv_scheduler: RTL and testbench

Shared M-extension unit with its sequencer for the dual-issue core. Two issue lanes compete for one multiply/divide resource, and a round-robin arbiter grants one lane at a time. Multiplies complete in one compute cycle; divides/remainders run a 32-step restoring iteration. Results return on a single response port tagged with lane and tag.

---
 rtl/muldiv_scheduler_if.sv | 49 ++++
 rtl/muldiv_scheduler.sv | 228 ++++++++++++++++++++++
 tb/tb_muldiv_scheduler.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_scheduler_if.sv
// muldiv_scheduler_if
//   Request/response bundle between the two issue lanes and the shared
//   multiply/divide unit.
//   Per lane: valid/ready handshake, funct3, rs1, rs2, tag.
//   Response: valid/ready handshake, lane, tag, data.
//   master: issue side (drives requests, consumes responses).
//   slave : muldiv_scheduler (accepts requests, produces responses).
interface muldiv_scheduler_if #(
    parameter int XLEN = 32,
    parameter int TAGW = 4
);
    logic            req0_valid;
    logic            req0_ready;
    logic [2:0]      req0_funct3;
    logic [XLEN-1:0] req0_rs1;
    logic [XLEN-1:0] req0_rs2;
    logic [TAGW-1:0] req0_tag;

    logic            req1_valid;
    logic            req1_ready;
    logic [2:0]      req1_funct3;
    logic [XLEN-1:0] req1_rs1;
    logic [XLEN-1:0] req1_rs2;
    logic [TAGW-1:0] req1_tag;

    logic            rsp_valid;
    logic            rsp_ready;
    logic            rsp_lane;
    logic [TAGW-1:0] rsp_tag;
    logic [XLEN-1:0] rsp_data;

    modport master (
        output req0_valid, req0_funct3, req0_rs1, req0_rs2, req0_tag,
        input  req0_ready,
        output req1_valid, req1_funct3, req1_rs1, req1_rs2, req1_tag,
        input  req1_ready,
        input  rsp_valid, rsp_lane, rsp_tag, rsp_data,
        output rsp_ready
    );

    modport slave (
        input  req0_valid, req0_funct3, req0_rs1, req0_rs2, req0_tag,
        output req0_ready,
        input  req1_valid, req1_funct3, req1_rs1, req1_rs2, req1_tag,
        output req1_ready,
        output rsp_valid, rsp_lane, rsp_tag, rsp_data,
        input  rsp_ready
    );
endinterface

// File: rtl/muldiv_scheduler.sv
// muldiv_scheduler
//   Shared RISC-V M-extension unit for a dual-issue core. Two lanes compete
//   for the unit through a round-robin arbiter; multiplies take one compute
//   cycle, divides/remainders run a 32-step restoring iteration. Results
//   return on one response port tagged with lane and tag.
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous active-high reset (has priority over flush)
//   flush - kills any in-flight op, no response is produced
//   bus   - muldiv_scheduler_if.slave (lane requests + response port)
//   busy  - high whenever the FSM is not IDLE
module muldiv_scheduler #(
    parameter int XLEN = 32,
    parameter int TAGW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    muldiv_scheduler_if.slave bus,
    output logic              busy
);
    localparam int CNTW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t          state_q, state_d;
    logic            rr_q, rr_d;
    logic [1:0]      op_q, op_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            negq_q, negq_d;
    logic            negr_q, negr_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_lane_q, rsp_lane_d;
    logic [TAGW-1:0] rsp_tag_q, rsp_tag_d;
    logic [XLEN-1:0] rsp_data_q, rsp_data_d;

    logic            idle_ok, grant0, grant1;
    logic [2:0]      sel_funct3;
    logic [XLEN-1:0] sel_rs1, sel_rs2;
    logic [TAGW-1:0] sel_tag;
    logic            div_signed, a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0] a_mag, b_mag, special_res;

    logic            a_sgn, b_sgn;
    logic [2*XLEN-1:0] a_ext, b_ext, prod;
    logic [XLEN-1:0] mul_res;

    logic [XLEN:0]   rem_shift, diff;
    logic [XLEN-1:0] quot_final, rem_final, div_res;

    // Arbiter: with both lanes valid the lane pointed to by rr_q wins, so
    // each lane gets at most one op between grants to the other.
    always_comb begin
        idle_ok = (state_q == IDLE) && !flush && !rst;
        grant0  = idle_ok && bus.req0_valid && (!bus.req1_valid || !rr_q);
        grant1  = idle_ok && bus.req1_valid && (!bus.req0_valid || rr_q);
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;

    // Accept-time decode: operand magnitudes for signed divides and the
    // results of divide-by-zero / signed-overflow, which skip the iteration.
    always_comb begin
        sel_funct3 = grant1 ? bus.req1_funct3 : bus.req0_funct3;
        sel_rs1    = grant1 ? bus.req1_rs1    : bus.req0_rs1;
        sel_rs2    = grant1 ? bus.req1_rs2    : bus.req0_rs2;
        sel_tag    = grant1 ? bus.req1_tag    : bus.req0_tag;
        div_signed = !sel_funct3[0];
        a_neg      = div_signed && sel_rs1[XLEN-1];
        b_neg      = div_signed && sel_rs2[XLEN-1];
        a_mag      = a_neg ? -sel_rs1 : sel_rs1;
        b_mag      = b_neg ? -sel_rs2 : sel_rs2;
        div_zero   = (sel_rs2 == '0);
        div_ovf    = div_signed && (sel_rs1 == MIN_NEG) && (sel_rs2 == '1);
        if (div_zero) begin
            special_res = sel_funct3[1] ? sel_rs1 : '1;
        end else begin
            special_res = sel_funct3[1] ? '0 : sel_rs1;
        end
    end

    // Multiply: sign-extend each operand to 2*XLEN as the op requires; the
    // low 2*XLEN bits of the product are then correct for every signedness.
    always_comb begin
        a_sgn   = (op_q == 2'b01) || (op_q == 2'b10);
        b_sgn   = (op_q == 2'b01);
        a_ext   = {{XLEN{a_sgn && a_q[XLEN-1]}}, a_q};
        b_ext   = {{XLEN{b_sgn && b_q[XLEN-1]}}, b_q};
        prod    = a_ext * b_ext;
        mul_res = (op_q == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    // Restoring divide step: a_q shifts the dividend out at the top and the
    // quotient bits in at the bottom. The extra bit of diff is the borrow.
    always_comb begin
        rem_shift  = {rem_q, a_q[XLEN-1]};
        diff       = rem_shift - {1'b0, b_q};
        quot_final = negq_q ? -a_q : a_q;
        rem_final  = negr_q ? -rem_q : rem_q;
        div_res    = op_q[1] ? rem_final : quot_final;
    end

    // Sequencer. Special-case divides enter DONE with the result already
    // loaded and raise rsp_valid one cycle later, matching multiply latency.
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        negq_d      = negq_q;
        negr_d      = negr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_lane_d  = rsp_lane_q;
        rsp_tag_d   = rsp_tag_q;
        rsp_data_d  = rsp_data_q;

        case (state_q)
            IDLE: begin
                if (grant0 || grant1) begin
                    rr_d       = !grant1;
                    op_d       = sel_funct3[1:0];
                    rsp_lane_d = grant1;
                    rsp_tag_d  = sel_tag;
                    rem_d      = '0;
                    negq_d     = a_neg ^ b_neg;
                    negr_d     = a_neg;
                    if (!sel_funct3[2]) begin
                        a_d     = sel_rs1;
                        b_d     = sel_rs2;
                        state_d = MUL;
                    end else if (div_zero || div_ovf) begin
                        rsp_data_d = special_res;
                        state_d    = DONE;
                    end else begin
                        a_d     = a_mag;
                        b_d     = b_mag;
                        cnt_d   = CNTW'(XLEN);
                        state_d = DIV;
                    end
                end
            end
            MUL: begin
                rsp_data_d  = mul_res;
                rsp_valid_d = 1'b1;
                state_d     = DONE;
            end
            DIV: begin
                if (cnt_q == '0) begin
                    rsp_data_d  = div_res;
                    rsp_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    rem_d = diff[XLEN] ? rem_shift[XLEN-1:0] : diff[XLEN-1:0];
                    a_d   = {a_q[XLEN-2:0], !diff[XLEN]};
                    cnt_d = cnt_q - CNTW'(1);
                end
            end
            DONE: begin
                if (!rsp_valid_q) begin
                    rsp_valid_d = 1'b1;
                end else if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Flush drops everything in flight but keeps the fairness pointer.
        if (flush) begin
            state_d     = IDLE;
            rsp_valid_d = 1'b0;
            rsp_lane_d  = 1'b0;
            rsp_tag_d   = '0;
            rsp_data_d  = '0;
            a_d         = '0;
            b_d         = '0;
            rem_d       = '0;
            cnt_d       = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_q        <= 1'b0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            negq_q      <= 1'b0;
            negr_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_lane_q  <= 1'b0;
            rsp_tag_q   <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            negq_q      <= negq_d;
            negr_q      <= negr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_lane_q  <= rsp_lane_d;
            rsp_tag_q   <= rsp_tag_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_lane  = rsp_lane_q;
    assign bus.rsp_tag   = rsp_tag_q;
    assign bus.rsp_data  = rsp_data_q;
    assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_muldiv_scheduler.sv
// tb_muldiv_scheduler
//   Directed vectors with hand-computed results. Stimulus pushes expected
//   responses into a queue; an independent monitor pops and compares them
//   (lane, tag, data, first-valid cycle) whenever rsp_valid is high.
module tb_muldiv_scheduler;
    localparam int XLEN = 32;
    localparam int TAGW = 4;

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;
    localparam logic [2:0] F_REMU   = 3'b111;

    typedef struct {
        logic            lane;
        logic [TAGW-1:0] tag;
        logic [XLEN-1:0] data;
        int              due;
        int              id;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    logic busy;

    muldiv_scheduler_if #(.XLEN(XLEN), .TAGW(TAGW)) bus ();

    muldiv_scheduler #(.XLEN(XLEN), .TAGW(TAGW)) dut (
        .clk  (clk),
        .rst  (rst),
        .flush(flush),
        .bus  (bus.slave),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   n_rsp  = 0;
    int   vec_id = 0;

    exp_t mon_cur;
    bit   mon_active = 1'b0;
    bit   mon_have   = 1'b0;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic drive_req(input logic lane, input logic [2:0] f3, input logic [XLEN-1:0] a,
                             input logic [XLEN-1:0] b, input logic [TAGW-1:0] tag);
        if (!lane) begin
            bus.req0_valid  = 1'b1;
            bus.req0_funct3 = f3;
            bus.req0_rs1    = a;
            bus.req0_rs2    = b;
            bus.req0_tag    = tag;
        end else begin
            bus.req1_valid  = 1'b1;
            bus.req1_funct3 = f3;
            bus.req1_rs1    = a;
            bus.req1_rs2    = b;
            bus.req1_tag    = tag;
        end
    endtask

    task automatic drop_req(input logic lane);
        if (!lane) bus.req0_valid = 1'b0;
        else       bus.req1_valid = 1'b0;
    endtask

    task automatic push_exp(input logic lane, input logic [TAGW-1:0] tag, input logic [XLEN-1:0] data, input int lat);
        exp_t e;
        e.lane = lane;
        e.tag  = tag;
        e.data = data;
        e.due  = cyc + lat;
        e.id   = vec_id;
        exp_q.push_back(e);
        vec_id++;
    endtask

    // Issue one request and wait (bounded) for its accept; returns one
    // cycle after the accepting edge.
    task automatic apply_stimulus(input logic lane, input logic [2:0] f3, input logic [XLEN-1:0] a,
                                  input logic [XLEN-1:0] b, input logic [TAGW-1:0] tag,
                                  input logic [XLEN-1:0] exp_data, input int lat, input bit expect_rsp);
        bit got = 1'b0;
        drive_req(lane, f3, a, b, tag);
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk);
            if ((lane ? bus.req1_ready : bus.req0_ready) === 1'b1) begin
                got = 1'b1;
                if (expect_rsp) push_exp(lane, tag, exp_data, lat);
            end
        end
        if (!got) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL accept_timeout lane %0d: ready 0, required 1", lane);
        end
        @(posedge clk);
        #1;
        drop_req(lane);
    endtask

    task automatic wait_rsp(input int target);
        int c = 0;
        while (n_rsp < target && c < 100) begin
            @(negedge clk);
            c++;
        end
        if (n_rsp < target) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL rsp_timeout: got %0d responses, required %0d", n_rsp, target);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input logic lane, input logic [2:0] f3, input logic [XLEN-1:0] a,
                           input logic [XLEN-1:0] b, input logic [TAGW-1:0] tag,
                           input logic [XLEN-1:0] exp_data, input int lat);
        int base = n_rsp;
        apply_stimulus(lane, f3, a, b, tag, exp_data, lat, 1'b1);
        wait_rsp(base + 1);
    endtask

    // Monitor: pops an expectation on the first valid cycle of a response,
    // checks latency once and lane/tag/data on every valid cycle.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst || !bus.rsp_valid) begin
                mon_active = 1'b0;
            end else begin
                if (!mon_active) begin
                    mon_active = 1'b1;
                    if (exp_q.size() == 0) begin
                        mon_have = 1'b0;
                        n_cmp++;
                        n_fail++;
                        $display("[TB] FAIL unexpected_rsp: got tag 0x%0h data 0x%0h, required no response",
                                 bus.rsp_tag, bus.rsp_data);
                    end else begin
                        mon_cur  = exp_q.pop_front();
                        mon_have = 1'b1;
                        check_output($sformatf("rsp_cycle#%0d", mon_cur.id), 64'(cyc), 64'(mon_cur.due));
                    end
                end
                if (mon_have) begin
                    check_output($sformatf("rsp_lane#%0d", mon_cur.id), 64'(bus.rsp_lane), 64'(mon_cur.lane));
                    check_output($sformatf("rsp_tag#%0d",  mon_cur.id), 64'(bus.rsp_tag),  64'(mon_cur.tag));
                    check_output($sformatf("rsp_data#%0d", mon_cur.id), 64'(bus.rsp_data), 64'(mon_cur.data));
                end
                if (bus.rsp_ready) begin
                    mon_active = 1'b0;
                    n_rsp++;
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int base;
        int grants;
        int last_grant;
        logic exp_lane;

        rst             = 1'b1;
        flush           = 1'b0;
        bus.rsp_ready   = 1'b1;
        bus.req0_valid  = 1'b0;
        bus.req0_funct3 = '0;
        bus.req0_rs1    = '0;
        bus.req0_rs2    = '0;
        bus.req0_tag    = '0;
        bus.req1_valid  = 1'b0;
        bus.req1_funct3 = '0;
        bus.req1_rs1    = '0;
        bus.req1_rs2    = '0;
        bus.req1_tag    = '0;

        // Reset state, with both lanes requesting while rst is high.
        drive_req(1'b0, F_MUL, 32'd1, 32'd1, 4'd1);
        drive_req(1'b1, F_MUL, 32'd1, 32'd1, 4'd2);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("reset_req0_ready", 64'(bus.req0_ready), 64'd0);
        check_output("reset_req1_ready", 64'(bus.req1_ready), 64'd0);
        check_output("reset_rsp_valid",  64'(bus.rsp_valid),  64'd0);
        check_output("reset_rsp_lane",   64'(bus.rsp_lane),   64'd0);
        check_output("reset_rsp_tag",    64'(bus.rsp_tag),    64'd0);
        check_output("reset_rsp_data",   64'(bus.rsp_data),   64'd0);
        check_output("reset_busy",       64'(busy),           64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drop_req(1'b0);
        drop_req(1'b1);

        // Multiplies
        run_vec(1'b0, F_MUL,    32'd7,        32'hFFFF_FFFD, 4'd3, 32'hFFFF_FFEB, 2);
        run_vec(1'b1, F_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd1, 32'hFFFF_FFFE, 2);
        run_vec(1'b0, F_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd2, 32'h0000_0000, 2);
        run_vec(1'b1, F_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd4, 32'hFFFF_FFFF, 2);
        // Normal divides
        run_vec(1'b0, F_DIV,    32'hFFFF_FFF9, 32'd2,        4'd5, 32'hFFFF_FFFD, 34);
        run_vec(1'b1, F_REM,    32'hFFFF_FFF9, 32'd2,        4'd6, 32'hFFFF_FFFF, 34);
        run_vec(1'b0, F_DIVU,   32'd100,       32'd7,        4'd7, 32'd14,        34);
        run_vec(1'b1, F_REMU,   32'd100,       32'd7,        4'd8, 32'd2,         34);
        run_vec(1'b0, F_DIV,    32'd100,       32'hFFFF_FFF9, 4'd14, 32'hFFFF_FFF2, 34);
        run_vec(1'b1, F_REM,    32'hFFFF_FF9C, 32'd7,        4'd15, 32'hFFFF_FFFE, 34);
        // Special divides
        run_vec(1'b0, F_DIV,    32'd5,         32'd0,        4'd9,  32'hFFFF_FFFF, 2);
        run_vec(1'b1, F_REM,    32'd5,         32'd0,        4'd10, 32'd5,         2);
        run_vec(1'b0, F_DIVU,   32'd5,         32'd0,        4'd13, 32'hFFFF_FFFF, 2);
        run_vec(1'b0, F_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 4'd11, 32'h8000_0000, 2);
        run_vec(1'b1, F_REM,    32'h8000_0000, 32'hFFFF_FFFF, 4'd12, 32'd0,        2);

        // Arbitration from a fresh reset: both lanes always valid.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        base       = n_rsp;
        grants     = 0;
        last_grant = 0;
        exp_lane   = 1'b0;
        drive_req(1'b0, F_MUL, 32'd3, 32'd4, 4'd1);
        drive_req(1'b1, F_MUL, 32'd5, 32'd6, 4'd2);
        for (int c = 0; c < 200 && grants < 4; c++) begin
            @(negedge clk);
            check_output("arb_one_ready", 64'(bus.req0_ready & bus.req1_ready), 64'd0);
            if (bus.req0_ready || bus.req1_ready) begin
                check_output("arb_grant_lane", 64'(bus.req1_ready), 64'(exp_lane));
                if (grants > 0) check_output("arb_grant_gap", 64'(cyc - last_grant), 64'd3);
                if (!exp_lane) push_exp(1'b0, 4'd1, 32'd12, 2);
                else           push_exp(1'b1, 4'd2, 32'd30, 2);
                last_grant = cyc;
                exp_lane   = ~exp_lane;
                grants++;
            end
        end
        if (grants < 4) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL arb_timeout: got %0d grants, required 4", grants);
        end
        @(posedge clk);
        #1;
        drop_req(1'b0);
        drop_req(1'b1);
        wait_rsp(base + 4);

        // Backpressure: response held 5 cycles, lane1 waiting is not accepted.
        base = n_rsp;
        bus.rsp_ready = 1'b0;
        apply_stimulus(1'b0, F_MULHU, 32'h0001_0000, 32'h0003_0000, 4'd5, 32'd3, 2, 1'b1);
        drive_req(1'b1, F_MUL, 32'd9, 32'd9, 4'd6);
        for (int c = 0; c < 10 && !bus.rsp_valid; c++) @(negedge clk);
        check_output("bp_rsp_valid_seen", 64'(bus.rsp_valid), 64'd1);
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            check_output("bp_rsp_valid_held", 64'(bus.rsp_valid),  64'd1);
            check_output("bp_req1_ready",     64'(bus.req1_ready), 64'd0);
            check_output("bp_busy",           64'(busy),           64'd1);
        end
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        apply_stimulus(1'b1, F_MUL, 32'd9, 32'd9, 4'd6, 32'd81, 2, 1'b1);
        wait_rsp(base + 2);

        // Flush while idle blocks the accept.
        drive_req(1'b0, F_MUL, 32'd2, 32'd2, 4'd7);
        flush = 1'b1;
        @(negedge clk);
        check_output("flush_idle_req0_ready", 64'(bus.req0_ready), 64'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        drop_req(1'b0);

        // Flush at DIV step 10: no response, idle next cycle, accept after.
        base = n_rsp;
        apply_stimulus(1'b0, F_DIVU, 32'd1000, 32'd3, 4'd7, 32'd333, 34, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        drive_req(1'b1, F_MUL, 32'd2, 32'd3, 4'd8);
        @(negedge clk);
        check_output("flush_busy_during", 64'(busy),           64'd1);
        check_output("flush_req1_ready",  64'(bus.req1_ready), 64'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check_output("flush_busy_after",   64'(busy),           64'd0);
        check_output("flush_rsp_valid",    64'(bus.rsp_valid),  64'd0);
        check_output("flush_next_accept",  64'(bus.req1_ready), 64'd1);
        if (bus.req1_ready) push_exp(1'b1, 4'd8, 32'd6, 2);
        @(posedge clk);
        #1;
        drop_req(1'b1);
        wait_rsp(base + 1);

        // Reset in the middle of a divide.
        apply_stimulus(1'b1, F_DIV, 32'd50, 32'd7, 4'd9, 32'd7, 34, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        @(negedge clk);
        check_output("rstdiv_busy_before", 64'(busy), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive_req(1'b0, F_MUL, 32'd1, 32'd1, 4'd1);
        @(negedge clk);
        check_output("rstdiv_req0_ready", 64'(bus.req0_ready), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_output("rstdiv_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check_output("rstdiv_rsp_lane",  64'(bus.rsp_lane),  64'd0);
        check_output("rstdiv_rsp_tag",   64'(bus.rsp_tag),   64'd0);
        check_output("rstdiv_rsp_data",  64'(bus.rsp_data),  64'd0);
        check_output("rstdiv_busy",      64'(busy),          64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drop_req(1'b0);

        // Unit still works after the reset.
        run_vec(1'b0, F_MUL, 32'd6, 32'd7, 4'd3, 32'd42, 2);

        repeat (3) @(posedge clk);
        check_output("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
